// File: rtl/line_buffer_seq_if.sv
// Pixel-stream, line-buffer SRAM and column-output signals of line_buffer_seq.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface line_buffer_seq_if #(
    parameter int KER_SIZE = 3,
    parameter int DW       = 32,
    parameter int IMG_W    = 32,
    parameter int AW       = $clog2(IMG_W)
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DW-1:0]                in_data;
    logic                         in_last;

    logic [KER_SIZE-1:0]          sram_wen;
    logic [KER_SIZE-1:0]          sram_ren;
    logic [AW-1:0]                sram_a;
    logic [DW-1:0]                sram_d;
    logic [(KER_SIZE-1)*DW-1:0]   sram_q;

    logic                         out_valid;
    logic                         out_ready;
    logic [KER_SIZE*DW-1:0]       out_data;
    logic                         out_eol;
    logic                         out_last;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        output sram_wen, sram_ren, sram_a, sram_d,
        input  sram_q,
        output out_valid, out_data, out_eol, out_last,
        input  out_ready
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  sram_wen, sram_ren, sram_a, sram_d,
        output sram_q,
        input  out_valid, out_data, out_eol, out_last,
        output out_ready
    );
endinterface

// File: rtl/line_buffer_seq.sv
// Line-buffer sequencer: writes raster rows round-robin into a KER_SIZE-row SRAM bank
// and emits a KER_SIZE-tall pixel column per input pixel once KER_SIZE-1 rows are stored.
module line_buffer_seq #(
    parameter int KER_SIZE = 3,
    parameter int DW       = 32,
    parameter int IMG_W    = 32,
    parameter int AW       = $clog2(IMG_W)
) (
    input logic           clk,
    input logic           rst,
    line_buffer_seq_if.slave bus
);
    localparam int RW = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;
    localparam int OW = KER_SIZE * DW;
    localparam logic [AW-1:0] COL_MAX = AW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(KER_SIZE - 1);

    typedef struct packed {
        logic [OW-1:0] data;
        logic          eol;
        logic          last;
    } entry_t;

    logic [AW-1:0] col;
    logic [RW-1:0] wr_row;
    logic [RW-1:0] filled;

    logic          pend_v;
    logic [DW-1:0] pend_d;
    logic          pend_eol;
    logic          pend_last;

    entry_t        fifo [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    occ;

    logic          steady;
    logic          fire;
    logic          pop;
    logic          has_data;
    logic [2:0]    credit;
    entry_t        head;

    assign steady   = (filled == ROW_MAX);
    assign has_data = (occ != 2'd0);
    assign pop      = has_data && bus.out_ready;

    // Count the pending entry as already occupying a FIFO slot so it always has room next cycle.
    assign credit       = 3'(occ) + 3'(pend_v) - 3'(pop);
    assign bus.in_ready = (credit < 3'd2);
    assign fire         = bus.in_valid && bus.in_ready;

    always_comb begin
        bus.sram_wen = '0;
        bus.sram_ren = '0;
        if (fire) begin
            bus.sram_wen = KER_SIZE'(1) << wr_row;
            if (steady) begin
                bus.sram_ren = ~(KER_SIZE'(1) << wr_row);
            end
        end
    end

    assign bus.sram_a = col;
    assign bus.sram_d = bus.in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            wr_row <= '0;
            filled <= '0;
        end else if (fire) begin
            if (bus.in_last) begin
                col    <= '0;
                wr_row <= '0;
                filled <= '0;
            end else if (col == COL_MAX) begin
                col    <= '0;
                wr_row <= (wr_row == ROW_MAX) ? '0 : wr_row + RW'(1);
                if (!steady) begin
                    filled <= filled + RW'(1);
                end
            end else begin
                col <= col + AW'(1);
            end
        end
    end

    // The array only presents q for one cycle after the access, so the pending slot bridges that gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_d    <= '0;
            pend_eol  <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend_v <= fire && steady;
            if (fire && steady) begin
                pend_d    <= bus.in_data;
                pend_eol  <= (col == COL_MAX);
                pend_last <= bus.in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else begin
            if (pend_v) begin
                fifo[wr_ptr].data <= {pend_d, bus.sram_q};
                fifo[wr_ptr].eol  <= pend_eol;
                fifo[wr_ptr].last <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(pend_v) - 2'(pop);
        end
    end

    assign head          = fifo[rd_ptr];
    assign bus.out_valid = has_data;
    assign bus.out_data  = has_data ? head.data : '0;
    assign bus.out_eol   = has_data ? head.eol  : 1'b0;
    assign bus.out_last  = has_data ? head.last : 1'b0;
endmodule

// File: tb/tb_line_buffer_seq.sv
// Randomized scoreboard bench for line_buffer_seq with a behavioural SRAM bank and
// a frame-level reference model of the expected pixel columns.
module tb_line_buffer_seq;
    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int IMG_W = 4;
    localparam int AW    = $clog2(IMG_W);
    localparam int OW    = K * DW;
    localparam int QW    = (K - 1) * DW;

    typedef struct {
        logic [OW-1:0] data;
        logic          eol;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    line_buffer_seq_if #(.KER_SIZE(K), .DW(DW), .IMG_W(IMG_W), .AW(AW)) bus ();

    line_buffer_seq #(.KER_SIZE(K), .DW(DW), .IMG_W(IMG_W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t          exp_q [$];
    logic [DW-1:0] frame [$];
    logic [OW-1:0] got_data [$];
    logic          got_eol [$];
    logic          got_last [$];
    logic [DW-1:0] mem [K][IMG_W];

    int            checks = 0;
    int            failures = 0;
    int            stalls = 0;
    int            cyc = 0;
    int            ready_mode = 0;
    logic          hold_prev = 1'b0;
    logic [OW-1:0] hold_data = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Row bank: q lists the rows other than the written one, newest first, and is zero after an idle cycle.
    always @(posedge clk) begin : sram_model
        int            w;
        logic [QW-1:0] q;
        w = 0;
        for (int i = 0; i < K; i++) begin
            if (bus.sram_wen[i]) w = i;
        end
        q = '0;
        for (int k = 1; k < K; k++) begin
            q = (q << DW) | QW'(bus.sram_ren[(w - k + K) % K] ? mem[(w - k + K) % K][bus.sram_a] : '0);
        end
        if (bus.sram_wen != '0) begin
            mem[w][bus.sram_a] <= bus.sram_d;
            bus.sram_q         <= q;
        end else begin
            bus.sram_q <= '0;
        end
    end

    always @(posedge clk) begin : ready_driver
        #1;
        cyc = cyc + 1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((cyc % 15) >= 10) ? 1'b0 : cyc[0];
            default: bus.out_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Reference: position in the frame decides the write row, whether a column is due, and its contents.
    always @(negedge clk) begin : ref_model
        int            idx;
        int            r;
        int            c;
        logic [OW-1:0] e;
        exp_t          x;
        if (!rst && bus.in_valid && bus.in_ready) begin
            idx = frame.size();
            r   = idx / IMG_W;
            c   = idx % IMG_W;
            checkOutput("sram_a", 64'(bus.sram_a), 64'(c));
            checkOutput("sram_d", 64'(bus.sram_d), 64'(bus.in_data));
            checkOutput("sram_wen", 64'(bus.sram_wen), 64'(1) << (r % K));
            checkOutput("sram_ren", 64'(bus.sram_ren),
                        (r >= K - 1) ? (~(64'(1) << (r % K)) & ((64'(1) << K) - 1)) : 64'(0));
            frame.push_back(bus.in_data);
            if (r >= K - 1) begin
                e = OW'(bus.in_data);
                for (int k = 1; k < K; k++) begin
                    e = (e << DW) | OW'(frame[(r - k) * IMG_W + c]);
                end
                x.data = e;
                x.eol  = (c == IMG_W - 1);
                x.last = bus.in_last;
                exp_q.push_back(x);
            end
            if (bus.in_last) frame.delete();
        end
    end

    always @(negedge clk) begin : protocol
        if (!rst) begin
            checkOutput("wen_onehot0", 64'($onehot0(bus.sram_wen)), 64'(1));
            checkOutput("wen_and_ren", 64'(bus.sram_wen & bus.sram_ren), 64'(0));
            if (bus.sram_wen == '0) checkOutput("ren_without_wen", 64'(bus.sram_ren), 64'(0));
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checkOutput("hold_valid", 64'(bus.out_valid), 64'(1));
                checkOutput("hold_data", 64'(bus.out_data), 64'(hold_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_eol.push_back(bus.out_eol);
                got_last.push_back(bus.out_last);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 64'(bus.out_data), 64'(0) - 1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", 64'(bus.out_data), 64'(e.data));
                    checkOutput("out_eol", 64'(bus.out_eol), 64'(e.eol));
                    checkOutput("out_last", 64'(bus.out_last), 64'(e.last));
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
        bit accepted = 1'b0;
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = bus.in_ready;
            if (!accepted) stalls++;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'(0), 64'(1));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        frame.delete();
        got_data.delete();
        got_eol.delete();
        got_last.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 64'(exp_q.size() != 0 || bus.out_valid), 64'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Column i of the 0..15 ramp frame once rows 2 and 3 produce output.
    function automatic logic [OW-1:0] rampCol(input int i);
        int r = 2 + i / IMG_W;
        int c = i % IMG_W;
        return {DW'(IMG_W * r + c), DW'(IMG_W * (r - 1) + c), DW'(IMG_W * (r - 2) + c)};
    endfunction

    task automatic checkRamp(input string tag);
        checkOutput({tag, "_count"}, 64'(got_data.size()), 64'(8));
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            checkOutput({tag, "_col"}, 64'(got_data[i]), 64'(rampCol(i)));
            checkOutput({tag, "_eol"}, 64'(got_eol[i]), 64'((i % IMG_W) == IMG_W - 1));
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("rst_out_data", 64'(bus.out_data), 64'(0));
        checkOutput("rst_out_eol", 64'(bus.out_eol), 64'(0));
        checkOutput("rst_out_last", 64'(bus.out_last), 64'(0));
        checkOutput("rst_sram_wen", 64'(bus.sram_wen), 64'(0));
        rst = 1'b0;

        $display("[TB] ramp frame, out_ready high");
        stalls = 0;
        for (int p = 0; p < 16; p++) applyStimulus(DW'(p), 1'b0);
        checkOutput("s1_stalls", 64'(stalls), 64'(0));
        drain();
        checkRamp("s1");

        $display("[TB] ramp frame under back-pressure");
        resetDut();
        ready_mode = 1;
        stalls = 0;
        for (int p = 0; p < 16; p++) applyStimulus(DW'(p), 1'b0);
        drain();
        checkOutput("s2_backpressure", 64'(stalls > 0), 64'(1));
        checkRamp("s2");
        ready_mode = 0;

        $display("[TB] truncated frame then new frame");
        resetDut();
        for (int p = 0; p < 10; p++) applyStimulus(DW'(p), p == 9);
        for (int p = 0; p < 12; p++) applyStimulus(DW'(100 + p), 1'b0);
        drain();
        checkOutput("s3_count", 64'(got_data.size()), 64'(6));
        if (got_data.size() >= 3) begin
            checkOutput("s3_col0", 64'(got_data[0]), {40'd0, 8'd8, 8'd4, 8'd0});
            checkOutput("s3_col1", 64'(got_data[1]), {40'd0, 8'd9, 8'd5, 8'd1});
            checkOutput("s3_last0", 64'(got_last[0]), 64'(0));
            checkOutput("s3_last1", 64'(got_last[1]), 64'(1));
            checkOutput("s3_newframe", 64'(got_data[2]), {40'd0, 8'd108, 8'd104, 8'd100});
        end

        $display("[TB] reset with a pending entry");
        resetDut();
        for (int p = 0; p < 10; p++) applyStimulus(DW'(p), 1'b0);
        checkOutput("s4_latency_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        #1;
        checkOutput("s4_rst_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("s4_rst_data", 64'(bus.out_data), 64'(0));
        checkOutput("s4_rst_last", 64'(bus.out_last), 64'(0));
        resetDut();
        checkOutput("s4_rst_ready", 64'(bus.in_ready), 64'(1));
        for (int p = 0; p < 16; p++) applyStimulus(DW'(p), 1'b0);
        drain();
        checkRamp("s4");

        $display("[TB] random stream with random gaps, stalls and frame ends");
        resetDut();
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
            applyStimulus(DW'($urandom), $urandom_range(0, 39) == 0);
        end
        drain();
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
